uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares one UART transmitter (transmit / tx_byte / is_transmitting handshake) between up to four packet sources, e.g. the uart_io response generator and a debug/interrupt reporter. Grants are packet-granular: a requester owns the transmitter from its first byte through the byte flagged last. Ownership rotates round-robin so no source starves. Sits between the packet sources and the UART core in the simulation and FPGA builds.

## Interface
- NUM_REQ, 2, number of requesters (legal 2..4)
- TIMEOUT_CYCLES, 255, stall limit in cycles (only with UART_ARB_TIMEOUT_EN; 8-bit, 1..255)
- clk  in  1  master clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  requester i has a byte on its lane
- req_byte  in  8*NUM_REQ  byte lanes; lane i = bits [8i+7:8i]
- req_last  in  NUM_REQ  lane i byte is the final byte of its packet
- req_ready  out  NUM_REQ  one-cycle pulse: lane i byte accepted
- grant  out  NUM_REQ  one-hot owner of the transmitter; all zero when idle
- transmit  out  1  one-cycle pulse to the UART core
- tx_byte  out  8  byte to the UART core; held until next accept
- is_transmitting  in  1  UART core busy flag
- timeout_err  out  1  one-cycle pulse when a grant is revoked by timeout

## Operation
- All outputs registered. Reset values: req_ready=0, grant=0, transmit=0, tx_byte=8'h00, timeout_err=0, state=IDLE, rr_ptr=NUM_REQ-1, last_flag=0, timer=0.
- IDLE: if any req_valid, pick the first asserted index searching rr_ptr+1, rr_ptr+2, … modulo NUM_REQ; set grant to that index; go OWNED.
- OWNED: when req_valid[g]=1 and is_transmitting=0: transmit=1, tx_byte=req_byte lane g, req_ready[g]=1, last_flag=req_last[g]; go WAIT_START. req_valid from non-granted lanes is ignored.
- WAIT_START: wait for is_transmitting=1; then go WAIT_DONE.
- WAIT_DONE: wait for is_transmitting=0; if last_flag: grant=0, rr_ptr=g, go IDLE; else go OWNED.
- Requester handshake: hold req_valid, req_byte and req_last stable until req_ready pulses; deassertion before that is legal and no byte is taken.
- Simultaneous requests in IDLE resolve by round robin only; after a packet completes, that requester has lowest priority.
- rr_ptr wraps NUM_REQ-1 → 0.
- Reset asserted mid-packet: immediate return to reset values; the partially sent packet is abandoned, and no completion pulse is generated.

## Timing
- Request to first transmit: req_valid high in IDLE at edge N → grant visible after N; transmit/req_ready visible after N+1 (UART idle).
- transmit, req_ready: exactly one cycle per accepted byte, same cycle, same lane.
- Byte to byte within packet: at least one cycle after is_transmitting falls (WAIT_DONE → OWNED → accept).
- Packet release: grant drops in the cycle after is_transmitting falls for the last byte; a new grant follows no earlier than the next edge.

## Configuration
- UART_ARB_TIMEOUT_EN defined: 8-bit timer clears on every state change and counts in OWNED and WAIT_START. On reaching TIMEOUT_CYCLES: grant=0, rr_ptr=g, timeout_err pulses one cycle, go IDLE. WAIT_DONE is never timed.
- Undefined: no timer logic; timeout_err is tied 0; OWNED/WAIT_START wait indefinitely.

## Test plan
- NUM_REQ=2, lane0 sends 8'h53,8'h31,8'h41 (last on 8'h41), UART busy 16 cycles/byte → three transmit pulses, tx_byte sequence 53/31/41, grant=01 throughout, grant=00 after final busy fall.
- Both lanes request 2-byte packets simultaneously after reset → lane0 packet first, then lane1; repeat with both held → lane0 again, confirming alternation.
- Lane1 raises req_valid during lane0's byte 2 of 4 → lane1 gets no req_ready until lane0's last byte completes; then grant=10.
- UART_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=20: lane0 sends non-last byte, then drops req_valid → timeout_err pulses 20 cycles after entering OWNED, grant=00, lane1 served next.
- rst pulsed during lane1 byte 2 → grant=00, transmit=0, tx_byte=00 immediately; next simultaneous request goes to lane0.
- NUM_REQ=3, all lanes continuously requesting 1-byte packets → grant order 0,1,2,0,1 (wrap-around verified).

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: packet-source lanes plus UART core handshake shared through uart_tx_arbiter
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_byte;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ-1:0]   grant;
    logic                 transmit;
    logic [7:0]           tx_byte;
    logic                 is_transmitting;
    logic                 timeout_err;

    modport master (
        output req_valid, req_byte, req_last, is_transmitting,
        input  req_ready, grant, transmit, tx_byte, timeout_err
    );

    modport slave (
        input  req_valid, req_byte, req_last, is_transmitting,
        output req_ready, grant, transmit, tx_byte, timeout_err
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-granular round-robin sharing of one UART transmitter; stall timeout enabled by UART_ARB_TIMEOUT_EN
module uart_tx_arbiter #(
    parameter int NUM_REQ = 2
`ifdef UART_ARB_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);
    localparam int PW = (NUM_REQ > 2) ? 2 : 1;

    typedef enum logic [1:0] {IDLE, OWNED, WAIT_START, WAIT_DONE} state_t;

    state_t             state, state_n;
    logic [PW-1:0]      rr_ptr, rr_n, owner, owner_n, pick;
    logic [NUM_REQ-1:0] grant, grant_n, ready, ready_n;
    logic               last_flag, last_n, transmit, transmit_n;
    logic [7:0]         tx_byte, tx_n;

    function automatic logic [PW-1:0] lane_after(input logic [PW-1:0] base, input int step);
        int j;
        j = int'(base) + step;
        return PW'(j >= NUM_REQ ? j - NUM_REQ : j);
    endfunction

    // Round-robin pick: scan from the farthest candidate back so the nearest lane after rr_ptr wins
    always_comb begin
        pick = rr_ptr;
        for (int i = NUM_REQ; i >= 1; i--)
            if (bus.req_valid[lane_after(rr_ptr, i)]) pick = lane_after(rr_ptr, i);
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [7:0] timer, timer_n;
    logic       timeout_err, timeout_n, timed, hit;
`endif

    // Next-state and next-output decode; the owner keeps the transmitter until its last byte drains
    always_comb begin
        state_n    = state;
        rr_n       = rr_ptr;
        owner_n    = owner;
        grant_n    = grant;
        ready_n    = '0;
        transmit_n = 1'b0;
        tx_n       = tx_byte;
        last_n     = last_flag;
        case (state)
            IDLE: if (|bus.req_valid) begin
                owner_n = pick;
                grant_n = NUM_REQ'(1) << pick;
                state_n = OWNED;
            end
            OWNED: if (bus.req_valid[owner] && !bus.is_transmitting) begin
                transmit_n = 1'b1;
                tx_n       = bus.req_byte[8*owner +: 8];
                ready_n    = NUM_REQ'(1) << owner;
                last_n     = bus.req_last[owner];
                state_n    = WAIT_START;
            end
            WAIT_START: if (bus.is_transmitting) state_n = WAIT_DONE;
            WAIT_DONE: if (!bus.is_transmitting) begin
                if (last_flag) begin
                    grant_n = '0;
                    rr_n    = owner;
                    state_n = IDLE;
                end else begin
                    state_n = OWNED;
                end
            end
            default: state_n = IDLE;
        endcase
`ifdef UART_ARB_TIMEOUT_EN
        timed     = (state_n == state) && (state == OWNED || state == WAIT_START);
        hit       = timed && (timer == 8'(TIMEOUT_CYCLES - 1));
        timer_n   = (timed && !hit) ? timer + 8'd1 : 8'd0;
        timeout_n = hit;
        if (hit) begin
            grant_n = '0;
            rr_n    = owner;
            state_n = IDLE;
        end
`endif
    end

    // Arbiter state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= PW'(NUM_REQ - 1);
            owner     <= '0;
            grant     <= '0;
            ready     <= '0;
            transmit  <= 1'b0;
            tx_byte   <= 8'h00;
            last_flag <= 1'b0;
        end else begin
            state     <= state_n;
            rr_ptr    <= rr_n;
            owner     <= owner_n;
            grant     <= grant_n;
            ready     <= ready_n;
            transmit  <= transmit_n;
            tx_byte   <= tx_n;
            last_flag <= last_n;
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    // Stall timer restarts on every state change; the error pulse marks a revoked grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer       <= 8'd0;
            timeout_err <= 1'b0;
        end else begin
            timer       <= timer_n;
            timeout_err <= timeout_n;
        end
    end

    assign bus.timeout_err = timeout_err;
`else
    assign bus.timeout_err = 1'b0;
`endif

    assign bus.grant     = grant;
    assign bus.req_ready = ready;
    assign bus.transmit  = transmit;
    assign bus.tx_byte   = tx_byte;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed checks of packet ownership, round robin, release timing, reset and optional timeout
module tb_uart_tx_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    uart_tx_arbiter_if #(.NUM_REQ(2)) b2 ();
    uart_tx_arbiter_if #(.NUM_REQ(3)) b3 ();

`ifdef UART_ARB_TIMEOUT_EN
    uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(20)) u2 (.clk(clk), .rst(rst), .bus(b2));
`else
    uart_tx_arbiter #(.NUM_REQ(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
`endif
    uart_tx_arbiter #(.NUM_REQ(3)) u3 (.clk(clk), .rst(rst), .bus(b3));

    always #5 clk = ~clk;

    // UART core models: busy for a fixed number of cycles after each transmit pulse
    int busy2, busy3;
    always @(posedge clk or posedge rst)
        if (rst) busy2 <= 0;
        else busy2 <= (busy2 != 0) ? busy2 - 1 : (b2.transmit ? 16 : 0);
    always @(posedge clk or posedge rst)
        if (rst) busy3 <= 0;
        else busy3 <= (busy3 != 0) ? busy3 - 1 : (b3.transmit ? 3 : 0);
    assign b2.is_transmitting = busy2 != 0;
    assign b3.is_transmitting = busy3 != 0;

    typedef struct packed {
        int         r;
        logic       t;
        logic [7:0] b;
        logic [1:0] g;
        int         c;
    } rec_t;

    logic [8:0] q0[$], q1[$];
    rec_t acc[$];
    int fall_q[$], drop_q[$], up_q[$];
    int tmo_count, tmo_idx;
    logic [1:0] tmo_grant;
    logic was_busy = 1'b0;
    logic [1:0] prev_grant = 2'b00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t at(input int i);
        rec_t r;
        r = '{r: -1, t: 1'bx, b: 8'hxx, g: 2'bxx, c: -1};
        if (i < acc.size()) r = acc[i];
        return r;
    endfunction

    task automatic drive2;
        logic [8:0] h0, h1;
        h0 = (q0.size() != 0) ? q0[0] : 9'd0;
        h1 = (q1.size() != 0) ? q1[0] : 9'd0;
        b2.req_valid = {q1.size() != 0, q0.size() != 0};
        b2.req_byte  = {h1[7:0], h0[7:0]};
        b2.req_last  = {h1[8], h0[8]};
    endtask

    task automatic clear_log;
        acc.delete();
        fall_q.delete();
        drop_q.delete();
        up_q.delete();
        tmo_count = 0;
        tmo_idx   = 0;
        tmo_grant = 2'b00;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        drive2();
        repeat (2) @(negedge clk);
        cyc += 2;
        rst = 1'b0;
        was_busy = 1'b0;
        prev_grant = 2'b00;
    endtask

    // Feed lanes from their queues, log every accept; stop after stop_n accepts or when all work has drained
    task automatic run2(input int max_cyc, input int stop_n);
        int n;
        n = 0;
        drive2();
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            cyc++;
            if (was_busy && !b2.is_transmitting) fall_q.push_back(cyc);
            was_busy = b2.is_transmitting;
            if (prev_grant != 2'b00 && b2.grant == 2'b00) drop_q.push_back(cyc);
            if (prev_grant == 2'b00 && b2.grant != 2'b00) up_q.push_back(cyc);
            prev_grant = b2.grant;
            if (b2.timeout_err) begin
                tmo_count++;
                tmo_idx   = cyc;
                tmo_grant = b2.grant;
            end
            if (b2.transmit || b2.req_ready != 2'b00) begin
                acc.push_back('{r: int'(b2.req_ready), t: b2.transmit, b: b2.tx_byte, g: b2.grant, c: cyc});
                if (b2.req_ready[0] && q0.size() != 0) void'(q0.pop_front());
                if (b2.req_ready[1] && q1.size() != 0) void'(q1.pop_front());
                n++;
            end
            drive2();
            if (stop_n > 0 && n == stop_n) break;
            if (stop_n == 0 && q0.size() == 0 && q1.size() == 0 && b2.grant == 2'b00) break;
        end
    endtask

    task automatic chk_seq(input string tag, input int n, input logic [63:0] be, input logic [15:0] le);
        rec_t r;
        chk({tag, "_count"}, acc.size(), n);
        for (int i = 0; i < n; i++) begin
            r = at(i);
            chk($sformatf("%s_byte%0d", tag, i), r.b, be[8*i +: 8]);
            chk($sformatf("%s_ready%0d", tag, i), r.r, 32'(le[2*i +: 2]));
            chk($sformatf("%s_grant%0d", tag, i), r.g, le[2*i +: 2]);
            chk($sformatf("%s_tx%0d", tag, i), r.t, 1'b1);
        end
    endtask

    initial begin
        rec_t r0, r1, r2;
        int start;
        logic [2:0] g3[$];
        logic [7:0] y3[$];
        logic [14:0] ge3;
        logic [39:0] be3;

        drive2();
        b3.req_valid = '0;
        b3.req_byte  = '0;
        b3.req_last  = '0;
        repeat (3) @(negedge clk);
        chk("rst_grant", b2.grant, 2'b00);
        chk("rst_transmit", b2.transmit, 1'b0);
        chk("rst_tx_byte", b2.tx_byte, 8'h00);
        chk("rst_ready", b2.req_ready, 2'b00);
        chk("rst_timeout", b2.timeout_err, 1'b0);
        chk("rst_grant3", b3.grant, 3'b000);
        rst = 1'b0;

        // Single three-byte packet on lane0
        clear_log;
        q0 = '{9'h053, 9'h031, 9'h141};
        start = cyc;
        run2(200, 0);
        chk_seq("t1", 3, 64'h0000_0000_0041_3153, 16'h0015);
        r0 = at(0);
        r1 = at(1);
        r2 = at(2);
        chk("t1_grant_up", (up_q.size() > 0) ? up_q[0] - start : -1, 1);
        chk("t1_first_tx", r0.c - start, 2);
        chk("t1_gap01", r1.c - r0.c, 19);
        chk("t1_gap12", r2.c - r1.c, 19);
        chk("t1_release", (drop_q.size() > 0 && fall_q.size() > 0) ? drop_q[0] - fall_q[fall_q.size()-1] : -1, 1);
        chk("t1_idle_grant", b2.grant, 2'b00);
        chk("t1_hold_byte", b2.tx_byte, 8'h41);

        // Simultaneous two-byte packets, twice: lane0 first both times
        do_reset;
        clear_log;
        q0 = '{9'h0A0, 9'h1A1};
        q1 = '{9'h0B0, 9'h1B1};
        run2(300, 0);
        chk_seq("t2a", 4, 64'h0000_0000_B1B0_A1A0, 16'h00A5);
        clear_log;
        q0 = '{9'h0C0, 9'h1C1};
        q1 = '{9'h0D0, 9'h1D1};
        run2(300, 0);
        chk_seq("t2b", 4, 64'h0000_0000_D1D0_C1C0, 16'h00A5);

        // Lane1 arrives mid-packet and must wait for lane0's last byte
        clear_log;
        q0 = '{9'h010, 9'h011, 9'h012, 9'h113};
        run2(200, 2);
        q1 = '{9'h120};
        run2(300, 0);
        chk_seq("t3", 5, 64'h0000_0020_1312_1110, 16'h0255);

        // Lane0 stalls after a non-last byte
        clear_log;
        q0 = '{9'h0E0};
        q1 = '{9'h1F0};
`ifdef UART_ARB_TIMEOUT_EN
        run2(300, 0);
        chk_seq("t4", 2, 64'h0000_0000_0000_F0E0, 16'h0009);
        chk("t4_tmo_count", tmo_count, 1);
        chk("t4_tmo_grant", tmo_grant, 2'b00);
        chk("t4_tmo_delay", (fall_q.size() > 0) ? tmo_idx - fall_q[0] : -1, 21);
`else
        run2(80, 0);
        chk_seq("t4", 1, 64'h0000_0000_0000_00E0, 16'h0001);
        chk("t4_tmo_count", tmo_count, 0);
        chk("t4_stuck_grant", b2.grant, 2'b01);
`endif

        // Reset in the middle of lane1's packet
        do_reset;
        clear_log;
        q1 = '{9'h021, 9'h022, 9'h123};
        run2(200, 2);
        chk_seq("t5a", 2, 64'h0000_0000_0000_2221, 16'h000A);
        rst = 1'b1;
        #1;
        chk("t5_rst_grant", b2.grant, 2'b00);
        chk("t5_rst_transmit", b2.transmit, 1'b0);
        chk("t5_rst_tx_byte", b2.tx_byte, 8'h00);
        chk("t5_rst_ready", b2.req_ready, 2'b00);
        q0.delete();
        q1.delete();
        drive2();
        @(negedge clk);
        cyc++;
        rst = 1'b0;
        was_busy = 1'b0;
        prev_grant = 2'b00;
        clear_log;
        q0 = '{9'h140};
        q1 = '{9'h141};
        run2(200, 0);
        chk_seq("t5b", 2, 64'h0000_0000_0000_4140, 16'h0009);

        // Three lanes continuously requesting single-byte packets
        b3.req_valid = 3'b111;
        b3.req_last  = 3'b111;
        b3.req_byte  = {8'h32, 8'h31, 8'h30};
        for (int c = 0; c < 200 && g3.size() < 5; c++) begin
            @(negedge clk);
            if (b3.transmit) begin
                g3.push_back(b3.grant);
                y3.push_back(b3.tx_byte);
            end
        end
        ge3 = 15'b010_001_100_010_001;
        be3 = 40'h31_30_32_31_30;
        chk("t6_count", g3.size(), 5);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t6_grant%0d", i), (i < g3.size()) ? g3[i] : 3'bxxx, ge3[3*i +: 3]);
            chk($sformatf("t6_byte%0d", i), (i < y3.size()) ? y3[i] : 8'hxx, be3[8*i +: 8]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
